// File: rtl/jb_aes_pkg.sv
// ---------------------------------------------------------------------------
// jb_aes_pkg
// Types and constants shared by the JB AES engines and the engine arbiter.
//   aes_state_t        : internal state encoding of the AES engines
//   arb_state_t        : arbiter FSM states
//   AES_ENGINE_LATENCY : cycles from an engine's nStart pulse to its nDone
// ---------------------------------------------------------------------------
package jb_aes_pkg;

  localparam int AES_ENGINE_LATENCY = 3;

  typedef enum logic [1:0] {
    AES_IDLE,
    AES_ROUNDS,
    AES_DONE
  } aes_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/jb_rr_picker.sv
// ---------------------------------------------------------------------------
// jb_rr_picker
// Combinational round-robin selector. Searches req_i upward, with
// wrap-around, starting one above last_grant_i; the first set bit wins.
// Usable by any shared-resource arbiter.
// Ports:
//   req_i        in  NUM_REQ  request vector
//   last_grant_i in  ID_W     index granted most recently
//   grant_o      out NUM_REQ  one-hot winner (all zero when no request)
//   id_o         out ID_W     binary index of the winner
//   any_o        out 1        at least one request present
// ---------------------------------------------------------------------------
module jb_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    grant_o = '0;
    id_o    = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_i) + k) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/jb_aes_arbiter.sv
// ---------------------------------------------------------------------------
// jb_aes_arbiter
// Shares one JB_AES_Encrypt and one JB_AES_Decrypt engine between NUM_REQ
// requesters. A round-robin winner's key/block/mode are latched, the chosen
// engine is started with a one-cycle active-low nStart, and its result is
// returned with a one-cycle rsp_valid pulse. One operation in flight at most.
//
// Optional feature macro: JB_AES_TIMEOUT_EN adds a BUSY watchdog and the
// rsp_err output.
//
// Ports:
//   clk, nRst                     clock, async active-low reset
//   req_valid/req_decrypt         per-requester request and mode (1=decrypt)
//   req_key/req_block             per-requester key and input block
//   req_grant                     one-hot, combinational acceptance
//   rsp_valid/rsp_block           one-hot response pulse and result
//   rsp_err                       watchdog abort (JB_AES_TIMEOUT_EN only)
//   busy                          high in every state except ARB_IDLE
//   eng_key/eng_blockin           latched operands to both engines
//   enc_nStart/dec_nStart         active-low engine starts
//   enc_nDone/dec_nDone           active-low engine completions
//   enc_blockout/dec_blockout     engine results
// ---------------------------------------------------------------------------
module jb_aes_arbiter
  import jb_aes_pkg::*;
#(
  parameter int BLOCK_WIDTH    = 128,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                clk,
  input  logic                                nRst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_decrypt,
  input  logic [NUM_REQ-1:0][BLOCK_WIDTH-1:0] req_key,
  input  logic [NUM_REQ-1:0][BLOCK_WIDTH-1:0] req_block,
  output logic [NUM_REQ-1:0]                  req_grant,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [BLOCK_WIDTH-1:0]              rsp_block,
`ifdef JB_AES_TIMEOUT_EN
  output logic                                rsp_err,
`endif
  output logic                                busy,
  output logic [BLOCK_WIDTH-1:0]              eng_key,
  output logic [BLOCK_WIDTH-1:0]              eng_blockin,
  output logic                                enc_nStart,
  output logic                                dec_nStart,
  input  logic                                enc_nDone,
  input  logic                                dec_nDone,
  input  logic [BLOCK_WIDTH-1:0]              enc_blockout,
  input  logic [BLOCK_WIDTH-1:0]              dec_blockout
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t               state_q, state_d;
  logic [ID_W-1:0]          last_grant_q, last_grant_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic                     mode_q, mode_d;          // 1 = decrypt
  logic [BLOCK_WIDTH-1:0]   key_q, key_d;
  logic [BLOCK_WIDTH-1:0]   blk_q, blk_d;
  logic [BLOCK_WIDTH-1:0]   rsp_block_q, rsp_block_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic                     busy_q, busy_d;
  logic                     enc_nstart_q, enc_nstart_d;
  logic                     dec_nstart_q, dec_nstart_d;
`ifdef JB_AES_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     rsp_err_q, rsp_err_d;
`endif

  logic [NUM_REQ-1:0]       pick_grant;
  logic [ID_W-1:0]          pick_id;
  logic                     pick_any;
  logic                     sel_ndone;
  logic [BLOCK_WIDTH-1:0]   sel_blockout;

  jb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .id_o         (pick_id),
    .any_o        (pick_any)
  );

  // Only the engine selected by the latched mode is listened to; the other
  // engine's nDone and blockout are ignored.
  assign sel_ndone    = mode_q ? dec_nDone    : enc_nDone;
  assign sel_blockout = mode_q ? dec_blockout : enc_blockout;

  // Grant is offered only while idle and out of reset, so it can never
  // coincide with a response pulse.
  assign req_grant = (state_q == ARB_IDLE && nRst) ? pick_grant : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    mode_d       = mode_q;
    key_d        = key_q;
    blk_d        = blk_q;
    rsp_block_d  = rsp_block_q;
`ifdef JB_AES_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d      = ARB_START;
          id_d         = pick_id;
          last_grant_d = pick_id;
          mode_d       = req_decrypt[pick_id];
          key_d        = req_key[pick_id];
          blk_d        = req_block[pick_id];
        end
      end
      ARB_START: begin
        state_d = ARB_BUSY;
`ifdef JB_AES_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ARB_BUSY: begin
        if (!sel_ndone) begin
          state_d     = ARB_RESP;
          rsp_block_d = sel_blockout;
`ifdef JB_AES_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d     = ARB_RESP;
          rsp_block_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
`endif
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    // Output registers are loaded from the next state so the pulses line
    // up with the state they belong to without combinational decoding.
    busy_d       = (state_d != ARB_IDLE);
    enc_nstart_d = !(state_d == ARB_START && !mode_d);
    dec_nstart_d = !(state_d == ARB_START &&  mode_d);
    rsp_valid_d  = '0;
    if (state_d == ARB_RESP) rsp_valid_d[id_d] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      mode_q       <= 1'b0;
      key_q        <= '0;
      blk_q        <= '0;
      rsp_block_q  <= '0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
      enc_nstart_q <= 1'b1;
      dec_nstart_q <= 1'b1;
`ifdef JB_AES_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      mode_q       <= mode_d;
      key_q        <= key_d;
      blk_q        <= blk_d;
      rsp_block_q  <= rsp_block_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      enc_nstart_q <= enc_nstart_d;
      dec_nstart_q <= dec_nstart_d;
`ifdef JB_AES_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_block   = rsp_block_q;
  assign busy        = busy_q;
  assign eng_key     = key_q;
  assign eng_blockin = blk_q;
  assign enc_nStart  = enc_nstart_q;
  assign dec_nStart  = dec_nstart_q;
`ifdef JB_AES_TIMEOUT_EN
  assign rsp_err     = rsp_err_q;
`endif

endmodule

// File: doc/jb_aes_arbiter.md
# jb_aes_arbiter

Shares one JB_AES_Encrypt and one JB_AES_Decrypt engine between NUM_REQ requesters. It selects one request at a time with round-robin arbitration and latches that request's key, block and mode. It then sequences the chosen engine through its active-low nStart/nDone handshake and returns the result to the requester as a one-cycle response. The block sits between the requesting clients and the two engine instances; at most one operation is in flight.

## Interface
- BLOCK_WIDTH, 128: key/block width; must equal the engines' BLOCK_WIDTH (128, 192 or 256)
- NUM_REQ, 4: number of requesters, 2..8
- TIMEOUT_CYCLES, 16: watchdog limit in BUSY; used only with JB_AES_TIMEOUT_EN
- clk  in  1  clock
- nRst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request pending
- req_decrypt  in  NUM_REQ  per-requester mode: 1 = decrypt, 0 = encrypt
- req_key  in  NUM_REQ x BLOCK_WIDTH  per-requester key
- req_block  in  NUM_REQ x BLOCK_WIDTH  per-requester input block
- req_grant  out  NUM_REQ  one-hot, combinational; request accepted this cycle
- rsp_valid  out  NUM_REQ  one-hot one-cycle pulse; result for that requester
- rsp_block  out  BLOCK_WIDTH  result; valid while any rsp_valid bit is high
- rsp_err  out  1  watchdog abort flag, qualified by rsp_valid; exists only with JB_AES_TIMEOUT_EN
- busy  out  1  high in every state except ARB_IDLE
- eng_key  out  BLOCK_WIDTH  latched key, drives both engines
- eng_blockin  out  BLOCK_WIDTH  latched block, drives both engines
- enc_nStart / dec_nStart  out  1  active-low start to encrypt / decrypt engine
- enc_nDone / dec_nDone  in  1  active-low done from encrypt / decrypt engine
- enc_blockout / dec_blockout  in  BLOCK_WIDTH  engine results

## Operation
- FSM states: ARB_IDLE, ARB_START, ARB_BUSY, ARB_RESP.
- **ARB_IDLE**
  - If any req_valid bit is set, pick the first set bit searching upward, with wrap-around, from last_grant+1.
  - Assert req_grant for the winner in the same cycle.
  - At the clock edge: latch eng_key, eng_blockin, mode and id, set last_grant to id, then go to ARB_START.
- **ARB_START**
  - Drive the selected engine's nStart low for exactly this cycle. The other nStart stays high.
  - Go to ARB_BUSY.
- **ARB_BUSY**
  - Wait for the selected engine's nDone to go low.
  - At that edge: capture the selected blockout into rsp_block and go to ARB_RESP.
- **ARB_RESP**
  - rsp_valid[id] is high for one cycle, then return to ARB_IDLE.
- eng_key and eng_blockin hold from ARB_START through ARB_RESP, because the engines' outputs are combinational on them.
- Requesters may change or drop their inputs after the grant cycle.
- Any nDone that arrives outside ARB_BUSY, or from the unselected engine, is ignored.
- Grants and responses are never both asserted in the same cycle.
- Reset values:
  - state = ARB_IDLE, last_grant = NUM_REQ-1 (requester 0 wins first)
  - enc_nStart = dec_nStart = 1
  - req_grant = rsp_valid = 0
  - rsp_block = eng_key = eng_blockin = 0
  - busy = 0, rsp_err = 0
- Reset mid-operation: an in-flight request is dropped with no response. The engines share nRst.

## Timing
- Cycle 0: ARB_IDLE with req_valid set; grant is asserted.
- Cycle 1: ARB_START, nStart low.
- Cycles 2–4: ARB_BUSY; with the standard engine, nDone is low in cycle 4.
- Cycle 5: ARB_RESP, rsp_valid high.
- Request-to-response latency is 5 cycles. The next grant comes no earlier than cycle 6, so peak throughput is one operation per 6 cycles.
- A request that stays asserted through another requester's grant is served in round-robin order. Worst-case wait is (NUM_REQ-1) x 6 cycles.
- busy is registered: high from cycle 1 through cycle 5.

## Configuration
- JB_AES_TIMEOUT_EN defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to ARB_BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no nDone, go to ARB_RESP with rsp_err = 1 and rsp_block = 0.
  - rsp_err = 0 on normal completion.
- JB_AES_TIMEOUT_EN undefined:
  - The counter and the rsp_err port are absent.
  - ARB_BUSY waits indefinitely for nDone.

## Structure
- Package jb_aes_pkg holds:
  - aes_state_t, moved from the engines' compilation unit
  - new arb_state_t {ARB_IDLE, ARB_START, ARB_BUSY, ARB_RESP}
  - localparam AES_ENGINE_LATENCY = 3
- Sub-module jb_rr_picker is combinational:
  - inputs: req vector, last_grant
  - outputs: one-hot grant, binary id, any
  - Reusable by other shared-resource arbiters.

## Test plan
- **Single request:** requester 2, encrypt, key = 0xFF..FF, block = 0x0F..0F. Required: req_grant[2] in cycle 0, enc_nStart low in cycle 1 only, rsp_valid[2] in cycle 5 with rsp_block = 0xF0..F0, dec_nStart never low.
- **Round-robin:** all four requesters hold valid continuously. Required: grants in order 0, 1, 2, 3, 0 at 6-cycle spacing, each rsp_valid matching its id.
- **Decrypt routing:** requester 1, decrypt. Required: only dec_nStart pulses; enc_nDone forced low during BUSY is ignored; response comes from dec_blockout.
- **Reset mid-operation:** nRst low in cycle 3. Required: all outputs return to reset values immediately, no rsp_valid, and requester 0 wins the next grant.
- **Timeout (JB_AES_TIMEOUT_EN, TIMEOUT_CYCLES = 16):** stubbed engine never asserts nDone. Required: rsp_valid with rsp_err = 1 and rsp_block = 0 in cycle 2+16+1 = 19, then the FSM returns to ARB_IDLE.
